apb_req_master: RTL and testbench
=================================

APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, address width of the command and PADDR.
REQ-002 Parameter: DATA_WIDTH, default 32, data width; a multiple of 8; PSTRB width is DATA_WIDTH/8.
REQ-003 Parameter: TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles; range 1..255.
REQ-004 Clocking and reset: one clock, PCLK; reset PRESET is synchronous and active-high.
REQ-005 PCLK  in  1  clock; all state changes on the rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  in  DATA_WIDTH  write data.
REQ-012 cmd_strb  in  DATA_WIDTH/8  write byte strobes.
REQ-013 cmd_prot  in  3  protection attributes.
REQ-014 cmd_nse  in  1  non-secure extension attribute.
REQ-015 rsp_valid  out  1  response available.
REQ-016 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-017 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
REQ-018 rsp_err  out  1  slave error or timeout.
REQ-019 rsp_timeout  out  1  transfer aborted by timeout.
REQ-020 APB outputs (all registered): PADDR [ADDR_WIDTH], PPROT [3], PNSE [1], PSEL [1], PENABLE [1], PWRITE [1], PWDATA [DATA_WIDTH], PSTRB [DATA_WIDTH/8], PWAKEUP [1].
REQ-021 APB inputs: PREADY [1], PRDATA [DATA_WIDTH], PSLVERR [1].

Function
REQ-022 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; in IDLE, cmd_valid=1 SHALL capture all cmd_* fields and move the FSM to SETUP.
REQ-024 SETUP SHALL last exactly one cycle with PSEL=1, PENABLE=0, then move to ACCESS.
REQ-025 ACCESS SHALL drive PSEL=1, PENABLE=1, and hold there while PREADY=0 and the wait count is below TIMEOUT_CYCLES.
REQ-026 From SETUP through the final ACCESS cycle, PADDR, PPROT, PNSE, PWRITE, PWDATA and PSTRB SHALL hold stable at the captured values.
REQ-027 PSTRB SHALL be driven to all zeros on reads.
REQ-028 In ACCESS, PREADY=1 SHALL complete the transfer and move to RESP on the next edge.
REQ-029 On completion, rsp_rdata SHALL take PRDATA for reads and 0 for writes; rsp_err SHALL take PSLVERR; rsp_timeout SHALL be 0.
REQ-030 The wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-031 When the wait count reaches TIMEOUT_CYCLES with PREADY still 0, the FSM SHALL abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-032 A timeout abort SHALL deassert PSEL and PENABLE on the same edge.
REQ-033 PREADY=1 in the cycle the wait count reaches TIMEOUT_CYCLES SHALL count as normal completion, not a timeout.
REQ-034 PSEL and PENABLE SHALL be 0 in IDLE and RESP; PENABLE SHALL never be 1 while PSEL is 0.
REQ-035 In RESP, rsp_valid SHALL be 1 and all rsp_* fields SHALL be stable; rsp_ready=1 SHALL return the FSM to IDLE.
REQ-036 A new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-037 PWAKEUP SHALL be registered as (state != IDLE) OR cmd_valid.
REQ-038 Minimum latency: command accepted at edge N gives SETUP in cycle N+1, ACCESS in N+2, and with PREADY=1 in N+2, rsp_valid=1 in N+3.

Reset
REQ-039 PRESET=1 SHALL force IDLE, clear the wait counter, and set every output to 0, in any state including mid-transfer.
REQ-040 Outputs SHALL remain 0 during reset, except cmd_ready, which SHALL be 1 from the first cycle after PRESET deasserts.

Verification
REQ-041 Write addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY=1 in the first ACCESS cycle -> PWRITE=1 with PSTRB=0xF through SETUP/ACCESS; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
REQ-042 Read addr=0x20 with PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678 -> ACCESS lasts 4 cycles with PADDR stable; rsp_rdata=0x12345678; PSTRB=0.
REQ-043 Read with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
REQ-044 TIMEOUT_CYCLES=4 with PREADY held 0 -> after 4 wait cycles, PSEL drops and rsp_err=1, rsp_timeout=1, rsp_rdata=0; a second run with PREADY=1 on the limit cycle -> normal completion.
REQ-045 rsp_ready held 0 for 5 cycles with cmd_valid held high -> rsp fields stable and cmd_ready=0 until the handshake; the next command is accepted the cycle after.
REQ-046 PRESET pulsed during ACCESS -> next cycle PSEL=PENABLE=rsp_valid=0 and the FSM is in IDLE; a following transfer completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// APB requester: turns one cmd/rsp handshake into one APB transfer,
// aborting an ACCESS phase that waits more than TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for cmd_valid
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, waiting for PREADY or timeout
// RESP   | response held on rsp_* until rsp_ready
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    input  logic                    cmd_nse,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [2:0]              PPROT,
    output logic                    PNSE,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PWAKEUP,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PADDR       <= '0;
            PPROT       <= '0;
            PNSE        <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PWAKEUP     <= 1'b0;
        end else begin
            PWAKEUP <= (state != IDLE) || cmd_valid;
            case (state)
                IDLE: begin
                    // cmd_ready is held low for the first cycle out of reset
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PADDR     <= cmd_addr;
                        PPROT     <= cmd_prot;
                        PNSE      <= cmd_nse;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over the timeout on the limit cycle
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed, table-driven bench for apb_req_master with TIMEOUT_CYCLES=4.
module tb_apb_req_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_nse;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [2:0]  PPROT;
    logic        PNSE, PSEL, PENABLE, PWRITE, PWAKEUP, PREADY, PSLVERR;
    logic [3:0]  PSTRB;

    int checks = 0;
    int failures = 0;
    int cur = -1;

    apb_req_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .cmd_nse(cmd_nse),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PWAKEUP(PWAKEUP), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        nse;
        int          delay;       // ACCESS cycles with PREADY low before it rises
        logic [31:0] prdata;
        logic        slverr;
        int          hold;        // cycles rsp_ready stays low in RESP
        logic        hold_valid;  // keep cmd_valid high through the whole transfer
        int          exp_acc;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s got=%0h exp=%0h", cur, name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"}, PSEL, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_pwakeup"}, PWAKEUP, 0);
        chk({tag, "_apb_bus"}, {PADDR, PWDATA}, 0);
        chk({tag, "_apb_ctl"}, {PPROT, PNSE, PWRITE, PSTRB}, 0);
        chk({tag, "_rsp_fields"}, {rsp_rdata, rsp_err, rsp_timeout}, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit done;
        cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
        cmd_strb = v.strb; cmd_prot = v.prot; cmd_nse = v.nse;
        cmd_valid = 1'b1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_psel", {PSEL, PENABLE}, 0);
        tick();
        cmd_valid = v.hold_valid;
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, v.addr);
        chk("setup_pwrite", PWRITE, v.write);
        chk("setup_pwdata", PWDATA, v.wdata);
        chk("setup_pstrb", PSTRB, v.exp_pstrb);
        chk("setup_pprot", {PPROT, PNSE}, {v.prot, v.nse});
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_pwakeup", PWAKEUP, 1);
        tick();
        n = 0;
        done = 0;
        while (!done && n < 12) begin
            chk("access_sel_en", {PSEL, PENABLE}, 2'b11);
            chk("access_paddr", PADDR, v.addr);
            chk("access_pwdata", PWDATA, v.wdata);
            chk("access_pstrb", PSTRB, v.exp_pstrb);
            chk("access_pwrite", PWRITE, v.write);
            chk("access_rsp_valid", rsp_valid, 0);
            PREADY  = (n >= v.delay);
            PRDATA  = (n >= v.delay) ? v.prdata : 32'h0;
            PSLVERR = (n >= v.delay) ? v.slverr : 1'b0;
            n++;
            tick();
            if (!PENABLE) done = 1;
        end
        PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;
        chk("access_cycles", n, v.exp_acc);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_sel_en", {PSEL, PENABLE}, 0);
        chk("resp_rdata", rsp_rdata, v.exp_rdata);
        chk("resp_err", rsp_err, v.exp_err);
        chk("resp_timeout", rsp_timeout, v.exp_to);
        chk("resp_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < v.hold; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_fields", {rsp_rdata, rsp_err, rsp_timeout}, {v.exp_rdata, v.exp_err, v.exp_to});
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_psel", PSEL, 0);
        if (!v.hold_valid) begin
            tick();
            chk("idle_pwakeup", PWAKEUP, 0);
            chk("idle_cmd_ready2", cmd_ready, 1);
        end
    endtask

    initial begin
        //           wr    addr          wdata         strb  prot    nse  dly  prdata        err  hold hv  acc pstrb  rdata         err  to
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 0, 32'hAAAA5555, 1'b0, 0, 1'b0, 1, 4'hF, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h20, 32'h11111111, 4'hF, 3'b000, 1'b0, 3, 32'h12345678, 1'b0, 0, 1'b0, 4, 4'h0, 32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h30, 32'h0,        4'h3, 3'b101, 1'b1, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0, 1, 4'h0, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h40, 32'h0,        4'h0, 3'b000, 1'b0, 255, 32'hFFFFFFFF, 1'b0, 1, 1'b0, 5, 4'h0, 32'h0,      1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h0, 3'b001, 1'b0, 4, 32'h0BADCAFE, 1'b0, 0, 1'b0, 5, 4'h0, 32'h0BADCAFE, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h50, 32'h01020304, 4'h5, 3'b000, 1'b1, 255, 32'h0,      1'b0, 0, 1'b0, 5, 4'h5, 32'h0,        1'b1, 1'b1};
        vecs[6] = '{1'b1, 32'h60, 32'h89ABCDEF, 4'hA, 3'b010, 1'b0, 2, 32'h77777777, 1'b1, 0, 1'b0, 3, 4'hA, 32'h0,        1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h70, 32'h55AA55AA, 4'hC, 3'b000, 1'b0, 1, 32'h0,        1'b0, 5, 1'b1, 2, 4'hC, 32'h0,        1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h80, 32'h0,        4'hF, 3'b110, 1'b1, 0, 32'h87654321, 1'b0, 0, 1'b0, 1, 4'h0, 32'h87654321, 1'b0, 1'b0};

        PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF0000;
        cmd_wdata = 32'h1234; cmd_strb = 4'hF; cmd_prot = 3'b111; cmd_nse = 1'b1;
        rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = 32'h0; PSLVERR = 1'b0;

        // Outputs stay zero under reset even with a pending command
        repeat (3) tick();
        chk_all_zero("reset");
        PRESET = 1'b0;
        cmd_valid = 1'b0;
        tick();
        chk("rel_cmd_ready", cmd_ready, 1);
        chk("rel_pwakeup", PWAKEUP, 0);
        chk("rel_psel", {PSEL, PENABLE}, 0);

        for (int i = 0; i < 9; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Reset pulse in the middle of an ACCESS wait
        cur = 100;
        cmd_write = 1'b0; cmd_addr = 32'h90; cmd_wdata = 32'h0; cmd_strb = 4'h0;
        cmd_prot = 3'b000; cmd_nse = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("mid_access_en", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        PRESET = 1'b0;
        tick();
        chk("mid_rel_cmd_ready", cmd_ready, 1);
        chk("mid_rel_psel", {PSEL, PENABLE, rsp_valid}, 0);
        cur = 101;
        run_vec(vecs[1]);
        cur = 102;
        run_vec(vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
